// File: rtl/scoreboard_hazard_unit.sv
// ID-stage hazard unit: load-use detection, a register scoreboard for one outstanding
// multi-cycle op, structural blocking, a multi-cycle watchdog and a stall-cycle counter.
module scoreboard_hazard_unit #(
    parameter int unsigned MC_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  id_rd,
    input  logic        id_reg_write,
    input  logic        id_is_load,
    input  logic        id_is_mc,
    input  logic        flush,
    input  logic        mc_done,
    input  logic [4:0]  mc_rd,
    output logic        stall,
    output logic        issue,
    output logic        mc_start,
    output logic [1:0]  stall_cause,
    output logic [31:0] sb_busy,
    output logic        mc_timeout,
    output logic [15:0] stall_count
);

    localparam logic [1:0] CauseNone    = 2'd0;
    localparam logic [1:0] CauseLoadUse = 2'd1;
    localparam logic [1:0] CauseSb      = 2'd2;
    localparam logic [1:0] CauseStruct  = 2'd3;

    logic [4:0]  ex_rd_q, ex_rd_d;
    logic        ex_load_q, ex_load_d;
    logic [31:0] sb_q, sb_d;
    logic        mc_busy_q, mc_busy_d;
    logic [7:0]  mc_cnt_q, mc_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        mc_done_eff;
    logic [31:0] done_mask;
    logic [31:0] sb_eff;
    logic        load_use;
    logic        sb_hazard;
    logic        struct_hazard;

    // A completion is only meaningful while an op is outstanding; otherwise it is ignored.
    always_comb begin
        mc_done_eff = mc_done & mc_busy_q;
        done_mask   = '0;
        if (mc_done_eff) begin
            done_mask[mc_rd] = 1'b1;
        end
        sb_eff = sb_q & ~done_mask & 32'hFFFF_FFFE;
    end

    always_comb begin
        load_use = ex_load_q && (ex_rd_q != 5'd0) &&
                   ((id_rs1_used && (id_rs1 == ex_rd_q)) ||
                    (id_rs2_used && (id_rs2 == ex_rd_q)));
        sb_hazard = (id_rs1_used & sb_eff[id_rs1]) |
                    (id_rs2_used & sb_eff[id_rs2]) |
                    (id_reg_write & sb_eff[id_rd]);
        struct_hazard = id_is_mc & mc_busy_q & ~mc_done_eff;
    end

    always_comb begin
        stall    = id_valid & ~flush & (load_use | sb_hazard | struct_hazard);
        issue    = id_valid & ~flush & ~stall;
        mc_start = issue & id_is_mc;

        stall_cause = CauseNone;
        if (stall) begin
            if (load_use) begin
                stall_cause = CauseLoadUse;
            end else if (sb_hazard) begin
                stall_cause = CauseSb;
            end else begin
                stall_cause = CauseStruct;
            end
        end
    end

    always_comb begin
        ex_rd_d   = issue ? id_rd : 5'd0;
        ex_load_d = issue & id_is_load & id_reg_write;

        sb_d      = sb_q;
        mc_busy_d = mc_busy_q;
        mc_cnt_d  = mc_cnt_q;

        if (mc_done_eff) begin
            sb_d[mc_rd] = 1'b0;
            mc_busy_d   = 1'b0;
        end
        if (mc_busy_q && (mc_cnt_q != 8'hFF)) begin
            mc_cnt_d = mc_cnt_q + 8'd1;
        end
        // Applied after the clear so a same-register restart keeps its bit set.
        if (mc_start) begin
            mc_busy_d = 1'b1;
            mc_cnt_d  = 8'd0;
            if (id_reg_write && (id_rd != 5'd0)) begin
                sb_d[id_rd] = 1'b1;
            end
        end
        sb_d[0] = 1'b0;

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rd_q     <= 5'd0;
            ex_load_q   <= 1'b0;
            sb_q        <= '0;
            mc_busy_q   <= 1'b0;
            mc_cnt_q    <= 8'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            ex_rd_q     <= ex_rd_d;
            ex_load_q   <= ex_load_d;
            sb_q        <= sb_d;
            mc_busy_q   <= mc_busy_d;
            mc_cnt_q    <= mc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign sb_busy     = sb_q;
    assign stall_count = stall_cnt_q;
    assign mc_timeout  = mc_busy_q && ({24'd0, mc_cnt_q} >= MC_TIMEOUT);

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Bench for scoreboard_hazard_unit: directed stimulus, a cycle-level reference model compared
// on every negative edge, and literal expectations for the key scenarios.
module tb_scoreboard_hazard_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_is_load;
    logic        id_is_mc;
    logic        flush;
    logic        mc_done;
    logic [4:0]  mc_rd;
    logic        stall;
    logic        issue;
    logic        mc_start;
    logic [1:0]  stall_cause;
    logic [31:0] sb_busy;
    logic        mc_timeout;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    scoreboard_hazard_unit #(.MC_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_reg_write(id_reg_write),
        .id_is_load  (id_is_load),
        .id_is_mc    (id_is_mc),
        .flush       (flush),
        .mc_done     (mc_done),
        .mc_rd       (mc_rd),
        .stall       (stall),
        .issue       (issue),
        .mc_start    (mc_start),
        .stall_cause (stall_cause),
        .sb_busy     (sb_busy),
        .mc_timeout  (mc_timeout),
        .stall_count (stall_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit [4:0] m_ex_rd;
    bit       m_ex_load;
    bit       m_sb [32];
    bit       m_busy;
    int       m_cnt;
    int       m_stalls;
    bit       chk_en = 1'b0;

    // Model outputs derived from the rules each cycle.
    bit        m_eff [32];
    bit        e_lu, e_sbh, e_st;
    bit        e_stall, e_issue, e_mcs;
    int        e_cause;
    bit [31:0] e_sb;
    bit        e_timeout;

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            m_eff[i] = (i != 0) && m_sb[i] && !(mc_done && m_busy && (int'(mc_rd) == i));
        end
        e_lu  = m_ex_load && (m_ex_rd != 0) &&
                ((id_rs1_used && id_rs1 == m_ex_rd) || (id_rs2_used && id_rs2 == m_ex_rd));
        e_sbh = (id_rs1_used && m_eff[id_rs1]) || (id_rs2_used && m_eff[id_rs2]) ||
                (id_reg_write && m_eff[id_rd]);
        e_st  = id_is_mc && m_busy && !mc_done;
        e_stall = id_valid && !flush && (e_lu || e_sbh || e_st);
        e_issue = id_valid && !flush && !e_stall;
        e_mcs   = e_issue && id_is_mc;
        if (!e_stall)   e_cause = 0;
        else if (e_lu)  e_cause = 1;
        else if (e_sbh) e_cause = 2;
        else            e_cause = 3;
        e_sb = '0;
        for (int i = 0; i < 32; i++) begin
            e_sb[i] = m_sb[i];
        end
        e_timeout = m_busy && (m_cnt >= int'(TO));
    end

    always @(posedge clk) begin
        if (rst) begin
            m_ex_rd   <= '0;
            m_ex_load <= 1'b0;
            for (int i = 0; i < 32; i++) m_sb[i] <= 1'b0;
            m_busy    <= 1'b0;
            m_cnt     <= 0;
            m_stalls  <= 0;
            chk_en    <= 1'b1;
        end else begin
            m_ex_rd   <= e_issue ? id_rd : 5'd0;
            m_ex_load <= e_issue && id_is_load && id_reg_write;
            if (mc_done && m_busy) begin
                m_sb[mc_rd] <= 1'b0;
                m_busy      <= 1'b0;
            end
            if (e_mcs) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                if (id_reg_write && id_rd != 0) m_sb[id_rd] <= 1'b1;
            end else if (m_busy) begin
                m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
            end
            if (e_stall) m_stalls <= (m_stalls < 65535) ? m_stalls + 1 : 65535;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", {31'd0, stall}, {31'd0, e_stall});
            chk("issue", {31'd0, issue}, {31'd0, e_issue});
            chk("mc_start", {31'd0, mc_start}, {31'd0, e_mcs});
            chk("stall_cause", {30'd0, stall_cause}, e_cause);
            chk("sb_busy", sb_busy, e_sb);
            chk("mc_timeout", {31'd0, mc_timeout}, {31'd0, e_timeout});
            chk("stall_count", {16'd0, stall_count}, m_stalls);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_reg_write = 0; id_is_load = 0; id_is_mc = 0;
        flush = 0; mc_done = 0; mc_rd = 0;
    endtask

    task automatic put(input bit [4:0] rs1, input bit u1, input bit [4:0] rs2, input bit u2,
                       input bit [4:0] rd, input bit wr, input bit ld, input bit mc);
        idle();
        id_valid = 1; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_reg_write = wr; id_is_load = ld; id_is_mc = mc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;
        #1; chk("rst_stall_count", {16'd0, stall_count}, 0);
        chk("rst_sb_busy", sb_busy, 0);

        // Load x5 followed by a reader of x5: one bubble.
        put(0, 0, 0, 0, 5, 1, 1, 0);
        #1; chk("ld_issue", {31'd0, issue}, 1); tick();
        put(5, 1, 0, 0, 6, 1, 0, 0);
        #1; chk("lu_stall", {31'd0, stall}, 1); chk("lu_cause", {30'd0, stall_cause}, 1); tick();
        #1; chk("lu_issue_after", {31'd0, issue}, 1); chk("lu_stall_after", {31'd0, stall}, 0);
        tick();
        idle(); tick();

        // MC op to x7, consumer waits until completion bypass.
        put(0, 0, 0, 0, 7, 1, 0, 1);
        #1; chk("mc_start_7", {31'd0, mc_start}, 1); tick();
        put(0, 0, 7, 1, 10, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1; chk("raw_cause", {30'd0, stall_cause}, 2); tick();
        end
        mc_done = 1; mc_rd = 7;
        #1; chk("bypass_issue", {31'd0, issue}, 1); chk("bypass_stall", {31'd0, stall}, 0); tick();
        idle(); #1; chk("sb_clear", sb_busy, 0); tick();

        // Second MC op blocked structurally, released by completion of the first.
        put(0, 0, 0, 0, 8, 1, 0, 1); tick();
        put(0, 0, 0, 0, 9, 1, 0, 1);
        #1; chk("struct_cause", {30'd0, stall_cause}, 3); tick();
        mc_done = 1; mc_rd = 8;
        #1; chk("struct_release", {31'd0, mc_start}, 1); tick();
        idle(); #1; chk("sb_new_rd_only", sb_busy, 32'h0000_0200); tick();
        put(0, 0, 0, 0, 9, 1, 0, 0);
        #1; chk("waw_cause", {30'd0, stall_cause}, 2); tick();

        // Flush overrides load-use and scoreboard hazards.
        put(0, 0, 0, 0, 5, 1, 1, 0); tick();
        put(5, 1, 9, 1, 11, 1, 0, 0); flush = 1;
        #1; chk("flush_stall", {31'd0, stall}, 0); chk("flush_issue", {31'd0, issue}, 0);
        chk("flush_cause", {30'd0, stall_cause}, 0); chk("flush_sb", sb_busy, 32'h0000_0200);
        tick();

        // Load-use outranks the scoreboard, which then takes over after the bubble.
        put(0, 0, 0, 0, 10, 1, 1, 0); tick();
        put(10, 1, 9, 1, 11, 1, 0, 0);
        #1; chk("prio_lu", {30'd0, stall_cause}, 1); tick();
        #1; chk("prio_sb", {30'd0, stall_cause}, 2); tick();
        idle(); mc_done = 1; mc_rd = 9; tick();
        idle(); mc_done = 1; mc_rd = 3; tick();
        idle(); #1; chk("spurious_done_sb", sb_busy, 0); tick();

        // Watchdog: count is 0 on the first busy cycle, so >=4 is reached on busy cycle 5.
        put(0, 0, 0, 0, 12, 1, 0, 1); tick();
        idle();
        for (int i = 1; i <= 6; i++) begin
            #1; chk("timeout_ramp", {31'd0, mc_timeout}, {31'd0, (i >= 5)}); tick();
        end
        rst = 1; tick(); rst = 0;
        #1; chk("rst2_stall", {31'd0, stall}, 0); chk("rst2_cause", {30'd0, stall_cause}, 0);
        chk("rst2_timeout", {31'd0, mc_timeout}, 0); chk("rst2_sb", sb_busy, 0);
        chk("rst2_count", {16'd0, stall_count}, 0);
        mc_done = 1; mc_rd = 12; tick();
        put(0, 0, 0, 0, 13, 1, 0, 1);
        #1; chk("post_rst_start", {31'd0, mc_start}, 1); tick();

        // Long stall behind x13 saturates the stall counter.
        put(13, 1, 0, 0, 14, 1, 0, 0);
        repeat (70000) tick();
        #1; chk("stall_sat", {16'd0, stall_count}, 32'h0000_FFFF);
        chk("timeout_held", {31'd0, mc_timeout}, 1);

        // Register 0 never creates a dependency.
        idle(); rst = 1; tick(); rst = 0;
        put(0, 0, 0, 0, 0, 1, 0, 1);
        #1; chk("x0_mc_start", {31'd0, mc_start}, 1); tick();
        put(0, 1, 0, 1, 0, 1, 0, 0);
        #1; chk("x0_no_stall", {31'd0, stall}, 0); chk("x0_sb", sb_busy, 0); tick();
        put(0, 0, 0, 0, 0, 1, 1, 0); tick();
        put(0, 1, 0, 0, 0, 1, 0, 0);
        #1; chk("x0_no_loaduse", {31'd0, stall}, 0); tick();
        idle(); tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
